// File: rtl/eager_fork_if.sv
// rtl/eager_fork_if.sv - handshake bundle between a producer, the eager fork and its consumers
interface eager_fork_if #(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = 32
);
  logic [DATA_TYPE-1:0]      ins;
  logic                      ins_valid;
  logic                      ins_ready;
  logic [SIZE*DATA_TYPE-1:0] outs;
  logic [SIZE-1:0]           outs_valid;
  logic [SIZE-1:0]           outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/eager_fork_register_block.sv
// rtl/eager_fork_register_block.sv - per-branch "already sent" flop of the eager fork
module eager_fork_register_block (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  input  logic outs_ready_i,
  input  logic backpressure_all,
  output logic outs_valid_i,
  output logic done_i
);
  logic sent_q;
  logic sent_d;

  assign outs_valid_i = ins_valid & ~sent_q;
  assign done_i       = sent_q | outs_ready_i;

  // Retiring the token clears every branch, overriding a same-cycle branch accept.
  always_comb begin
    sent_d = sent_q;
    if (ins_valid & ~backpressure_all) begin
      sent_d = 1'b0;
    end else if (outs_valid_i & outs_ready_i) begin
      sent_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_q <= 1'b0;
    end else begin
      sent_q <= sent_d;
    end
  end
endmodule

// File: rtl/eager_fork.sv
// rtl/eager_fork.sv - eager dataflow fork broadcasting one elastic token to SIZE consumers
module eager_fork #(
  parameter int SIZE      = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic         clk,
  input  logic         rst,
  eager_fork_if.slave  bus
);
  logic [SIZE-1:0] done;
  logic            backpressure_all;

  assign bus.ins_ready    = &done;
  assign backpressure_all = ~bus.ins_ready;

  for (genvar g = 0; g < SIZE; g++) begin : g_branch
    eager_fork_register_block u_reg (
      .clk              (clk),
      .rst              (rst),
      .ins_valid        (bus.ins_valid),
      .outs_ready_i     (bus.outs_ready[g]),
      .backpressure_all (backpressure_all),
      .outs_valid_i     (bus.outs_valid[g]),
      .done_i           (done[g])
    );

    assign bus.outs[g*DATA_TYPE +: DATA_TYPE] = bus.ins;
  end
endmodule

// File: tb/tb_eager_fork.sv
// tb/tb_eager_fork.sv - self-checking bench for eager_fork at SIZE 2, 3 and 4
module tb_eager_fork;
  localparam int DW = 32;
  localparam int NTOK = 1000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  eager_fork_if #(.SIZE(2), .DATA_TYPE(DW)) if2 ();
  eager_fork_if #(.SIZE(3), .DATA_TYPE(DW)) if3 ();
  eager_fork_if #(.SIZE(4), .DATA_TYPE(DW)) if4 ();

  eager_fork #(.SIZE(2), .DATA_TYPE(DW)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  eager_fork #(.SIZE(3), .DATA_TYPE(DW)) dut3 (.clk(clk), .rst(rst), .bus(if3));
  eager_fork #(.SIZE(4), .DATA_TYPE(DW)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    if2.ins = '0; if2.ins_valid = 1'b0; if2.outs_ready = '0;
    if3.ins = '0; if3.ins_valid = 1'b0; if3.outs_ready = '0;
    if4.ins = '0; if4.ins_valid = 1'b0; if4.outs_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    if2.ins = 32'h3F800000; if2.ins_valid = 1'b1; if2.outs_ready = 2'b00;
    #1;
    n_checks++;
    if (if2.outs_valid !== 2'b11 || if2.ins_ready !== 1'b0)
      $display("FAIL reset_state outs_valid=%b ins_ready=%b want 11/0", if2.outs_valid, if2.ins_ready);
    else n_pass++;
  endtask

  task automatic test_broadcast();
    @(negedge clk);
    if2.outs_ready = 2'b11;
    #1;
    n_checks++;
    if (if2.outs_valid !== 2'b11 || if2.ins_ready !== 1'b1 ||
        if2.outs[31:0] !== 32'h3F800000 || if2.outs[63:32] !== 32'h3F800000)
      $display("FAIL broadcast outs_valid=%b ins_ready=%b outs=%h want 11/1/3f8000003f800000",
               if2.outs_valid, if2.ins_ready, if2.outs);
    else n_pass++;
    @(negedge clk);
    if2.outs_ready = 2'b00;
    #1;
    n_checks++;
    if (if2.outs_valid !== 2'b11)
      $display("FAIL broadcast_no_state outs_valid=%b want 11", if2.outs_valid);
    else n_pass++;
  endtask

  task automatic test_staggered();
    @(negedge clk);
    if2.ins = 32'hA5A5_0001; if2.outs_ready = 2'b01;
    #1;
    n_checks++;
    if (if2.ins_ready !== 1'b0 || if2.outs_valid !== 2'b11)
      $display("FAIL stagger_c0 ins_ready=%b outs_valid=%b want 0/11", if2.ins_ready, if2.outs_valid);
    else n_pass++;
    @(negedge clk);
    if2.outs_ready = 2'b10;
    #1;
    n_checks++;
    if (if2.outs_valid !== 2'b10 || if2.ins_ready !== 1'b1)
      $display("FAIL stagger_c1 outs_valid=%b ins_ready=%b want 10/1", if2.outs_valid, if2.ins_ready);
    else n_pass++;
    @(negedge clk);
    if2.outs_ready = 2'b00;
    #1;
    n_checks++;
    if (if2.outs_valid !== 2'b11)
      $display("FAIL stagger_cleared outs_valid=%b want 11", if2.outs_valid);
    else n_pass++;
  endtask

  task automatic test_no_duplication();
    int xfers0;
    xfers0 = 0;
    @(negedge clk);
    if2.ins = 32'hDEAD_BEEF; if2.outs_ready = 2'b01;
    #1;
    if (if2.outs_valid[0] && if2.outs_ready[0]) xfers0++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (if2.outs_valid[0] && if2.outs_ready[0]) xfers0++;
      n_checks++;
      if (if2.outs_valid !== 2'b10 || if2.ins_ready !== 1'b0)
        $display("FAIL nodup_cycle%0d outs_valid=%b ins_ready=%b want 10/0", c, if2.outs_valid, if2.ins_ready);
      else n_pass++;
    end
    n_checks++;
    if (xfers0 != 1) $display("FAIL nodup_count branch0 transfers=%0d want 1", xfers0);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (if2.outs_valid !== 2'b11)
      $display("FAIL async_reset outs_valid=%b want 11 before any clk edge", if2.outs_valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    if2.outs_ready = 2'b00;
    @(negedge clk);
    #1;
    n_checks++;
    if (if2.outs_valid !== 2'b11)
      $display("FAIL async_reoffer outs_valid=%b want 11", if2.outs_valid);
    else n_pass++;
    if2.ins_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int got [3][$];
    int in_xfers;
    in_xfers = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if3.ins = k; if3.ins_valid = 1'b1; if3.outs_ready = 3'b111;
      #1;
      for (int i = 0; i < 3; i++)
        if (if3.outs_valid[i] && if3.outs_ready[i]) got[i].push_back(int'(if3.outs[i*DW +: DW]));
      if (if3.ins_valid && if3.ins_ready) in_xfers++;
    end
    @(negedge clk);
    if3.ins_valid = 1'b0; if3.outs_ready = 3'b000;
    n_checks++;
    if (in_xfers != 8) $display("FAIL stream_input_xfers got=%0d want 8", in_xfers);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      bit ok;
      ok = (got[i].size() == 8);
      for (int k = 0; k < got[i].size() && ok; k++) if (got[i][k] != k) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL stream_branch%0d received %0d tokens, want 0..7 in order", i, got[i].size());
      else n_pass++;
    end
  endtask

  task automatic test_random_backpressure();
    logic [DW-1:0] tokens [NTOK];
    int rcv [4];
    int p, cycles, retired, errs;
    bit idle;
    logic [3:0] exp_v;
    bit exp_r, all_took;
    for (int k = 0; k < NTOK; k++) tokens[k] = $urandom;
    for (int i = 0; i < 4; i++) rcv[i] = 0;
    p = 0; cycles = 0; retired = 0; errs = 0;
    while (p < NTOK && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      idle = (rcv[0] == p && rcv[1] == p && rcv[2] == p && rcv[3] == p) && ($urandom_range(0, 4) == 0);
      if4.ins_valid = !idle;
      if4.ins = tokens[p];
      if4.outs_ready = 4'($urandom);
      #1;
      exp_r = 1'b1;
      for (int i = 0; i < 4; i++) begin
        exp_v[i] = !idle && (rcv[i] == p);
        if (!(rcv[i] > p || if4.outs_ready[i])) exp_r = 1'b0;
      end
      n_checks++;
      if (if4.outs_valid !== exp_v) begin
        if (errs < 10) $display("FAIL rand_outs_valid tok=%0d got=%b want=%b", p, if4.outs_valid, exp_v);
        errs++;
      end else n_pass++;
      if (!idle) begin
        n_checks++;
        if (if4.ins_ready !== exp_r) begin
          if (errs < 10) $display("FAIL rand_ins_ready tok=%0d got=%b want=%b", p, if4.ins_ready, exp_r);
          errs++;
        end else n_pass++;
      end
      for (int i = 0; i < 4; i++) begin
        if (if4.outs_valid[i] && if4.outs_ready[i]) begin
          n_checks++;
          if (rcv[i] >= NTOK || if4.outs[i*DW +: DW] !== tokens[rcv[i]]) begin
            if (errs < 10) $display("FAIL rand_data branch%0d idx=%0d got=%h", i, rcv[i], if4.outs[i*DW +: DW]);
            errs++;
          end else n_pass++;
          rcv[i]++;
        end
      end
      if (if4.ins_valid && if4.ins_ready) begin
        all_took = (rcv[0] == p + 1 && rcv[1] == p + 1 && rcv[2] == p + 1 && rcv[3] == p + 1);
        n_checks++;
        if (!all_took) begin
          if (errs < 10) $display("FAIL rand_retire tok=%0d rcv=%0d,%0d,%0d,%0d want all %0d",
                                  p, rcv[0], rcv[1], rcv[2], rcv[3], p + 1);
          errs++;
        end else n_pass++;
        p++;
        retired++;
      end
    end
    if4.ins_valid = 1'b0; if4.outs_ready = '0;
    n_checks++;
    if (retired != NTOK) $display("FAIL rand_retired got=%0d want=%0d (cycles=%0d)", retired, NTOK, cycles);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rcv[i] != NTOK) $display("FAIL rand_branch%0d_count got=%0d want=%0d", i, rcv[i], NTOK);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_broadcast();
    test_staggered();
    test_no_duplication();
    test_async_reset();
    test_back_to_back();
    test_random_backpressure();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
